// File: rtl/pseudo_softmax_decoder_if.sv
// Stream bundle between the pseudo_softmax producer and its decoder.
// A transfer occurs on a rising edge where valid && ready; valid never depends on ready, and the payload holds while valid && !ready.
interface pseudo_softmax_decoder_if #(
    parameter int N_CLASSES = 10,
    parameter int W         = 8,
    parameter int PW        = 16
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           mant_in;
    logic [N_CLASSES*W-1:0] exp_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [PW-1:0]          out_prob;
    logic [3:0]             out_idx;
    logic                   out_last;

    modport master (
        output in_valid, mant_in, exp_in, out_ready,
        input  in_ready, out_valid, out_prob, out_idx, out_last
    );

    modport slave (
        input  in_valid, mant_in, exp_in, out_ready,
        output in_ready, out_valid, out_prob, out_idx, out_last
    );
endinterface

// File: rtl/pseudo_softmax_decoder.sv
// Expands one mantissa+exponent frame into N linear Q0.PW probabilities, one per cycle, tracking arg-max.
// Optional macro PSM_SUM_CHECK_EN adds the sum_ok port and the probability-sum accumulator.
module pseudo_softmax_decoder #(
    parameter int N_CLASSES = 10,
    parameter int W         = 8,
    parameter int PW        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pseudo_softmax_decoder_if.slave bus,
    output logic [3:0]             argmax,
    output logic                   argmax_valid,
    output logic                   busy
`ifdef PSM_SUM_CHECK_EN
    ,
    output logic                   sum_ok
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [3:0]          LAST_IDX = 4'(N_CLASSES - 1);
    localparam logic signed [W+1:0] S_OFF    = (W+2)'(PW - (W - 1));
    localparam logic signed [W+1:0] S_SAT    = (W+2)'(PW);
    localparam logic [W+1:0]        S_ZERO   = (W+2)'(W);

    state_t        state, state_next;
    logic [W-1:0]  mant_q;
    logic [W-1:0]  exp_q [N_CLASSES];
    logic [3:0]    idx_q, idx_next;
    logic          in_ready_q;
    logic [PW-1:0] prob_q;
    logic          last_q;
    logic [3:0]    best_idx;
    logic [W-1:0]  best_exp;
    logic [W-1:0]  exp_next;
    logic          accept, out_hs, last_hs;

    // value = mant * 2^(exp + PW - (W-1)), saturating high and truncating low.
    function automatic logic [PW-1:0] recon(input logic [W-1:0] mant, input logic [W-1:0] e);
        logic signed [W+1:0] s;
        logic [W+1:0]        neg;
        logic [PW+W-1:0]     wide;
        s     = $signed({{2{e[W-1]}}, e}) + S_OFF;
        neg   = '0;
        wide  = '0;
        recon = '0;
        if (!s[W+1]) begin
            if (s >= S_SAT) begin
                recon = (mant != '0) ? '1 : '0;
            end else begin
                wide = (PW+W)'(mant) << s;
                recon = (wide[PW+W-1:PW] != '0) ? '1 : wide[PW-1:0];
            end
        end else begin
            neg = -s;
            if (neg < S_ZERO) begin
                recon = PW'(mant >> neg);
            end
        end
    endfunction

    always_comb begin
        accept     = (state == IDLE) && in_ready_q && bus.in_valid;
        out_hs     = (state == RUN) && bus.out_ready;
        last_hs    = out_hs && (idx_q == LAST_IDX);
        idx_next   = idx_q + 4'd1;
        exp_next   = (int'(idx_next) < N_CLASSES) ? exp_q[idx_next] : '0;
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (last_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q   <= 1'b0;
            mant_q       <= '0;
            for (int i = 0; i < N_CLASSES; i++) exp_q[i] <= '0;
            idx_q        <= '0;
            prob_q       <= '0;
            last_q       <= 1'b0;
            best_idx     <= '0;
            best_exp     <= '0;
            argmax       <= '0;
            argmax_valid <= 1'b0;
        end else begin
            in_ready_q   <= (state_next == IDLE);
            argmax_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mant_q <= bus.mant_in;
                        for (int i = 0; i < N_CLASSES; i++) exp_q[i] <= bus.exp_in[W*i +: W];
                        idx_q  <= '0;
                    end
                end
                LOAD: begin
                    prob_q   <= recon(mant_q, exp_q[0]);
                    last_q   <= (LAST_IDX == 4'd0);
                    best_idx <= '0;
                    best_exp <= exp_q[0];
                end
                RUN: begin
                    if (last_hs) begin
                        argmax       <= best_idx;
                        argmax_valid <= 1'b1;
                    end else if (out_hs) begin
                        idx_q  <= idx_next;
                        prob_q <= recon(mant_q, exp_next);
                        last_q <= (idx_next == LAST_IDX);
                        // Shared mantissa: exponent order is probability order; ties keep the lower index.
                        if ($signed(exp_next) > $signed(best_exp)) begin
                            best_idx <= idx_next;
                            best_exp <= exp_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PSM_SUM_CHECK_EN
    localparam int            SW   = PW + 4;
    localparam logic [SW-1:0] ONE  = SW'(1) << PW;
    localparam logic [SW-1:0] TOL  = SW'(1) << (PW - 3);

    logic [SW-1:0] acc_q, sum_fin, diff;

    always_comb begin
        sum_fin = acc_q + SW'(prob_q);
        diff    = (sum_fin >= ONE) ? (sum_fin - ONE) : (ONE - sum_fin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            sum_ok <= 1'b0;
        end else begin
            if (accept)      acc_q <= '0;
            else if (out_hs) acc_q <= sum_fin;
            if (last_hs)     sum_ok <= (diff <= TOL);
        end
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state == RUN);
    assign bus.out_prob  = prob_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign busy          = (state == RUN);
endmodule

// File: tb/tb_pseudo_softmax_decoder.sv
// Directed bench for pseudo_softmax_decoder: hand-computed frames, backpressure, mid-frame reset.
module tb_pseudo_softmax_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] argmax;
    logic       argmax_valid;
    logic       busy;
`ifdef PSM_SUM_CHECK_EN
    logic       sum_ok;
`endif
    int         vectors = 0;
    int         miscompares = 0;
    logic [15:0] exp_q[$];

    pseudo_softmax_decoder_if #(.N_CLASSES(10), .W(8), .PW(16)) bus ();

    pseudo_softmax_decoder #(.N_CLASSES(10), .W(8), .PW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .argmax       (argmax),
        .argmax_valid (argmax_valid),
        .busy         (busy)
`ifdef PSM_SUM_CHECK_EN
        ,
        .sum_ok       (sum_ok)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_frame(input logic [7:0] mant, input logic [79:0] exps);
        int budget;
        budget = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("in_ready_wait", 32'(budget < 20), 32'd1);
        bus.mant_in  = mant;
        bus.exp_in   = exps;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [159:0] probs, input logic [3:0] exp_am,
                             input int stall_idx, input int stall_n, input int abort_at);
        logic [15:0] e;
        for (int i = 0; i < 10; i++) exp_q.push_back(probs[16*i +: 16]);
        @(negedge clk);
        chk("load_gap_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k == abort_at) begin
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_idx", 32'(bus.out_idx), 32'(k));
            chk("out_prob", 32'(bus.out_prob), 32'(e));
            chk("out_last", 32'(bus.out_last), 32'(k == 9));
            chk("busy_run", 32'(busy), 32'd1);
            chk("in_ready_run", 32'(bus.in_ready), 32'd0);
            chk("argmax_valid_mid", 32'(argmax_valid), 32'd0);
            if (k == stall_idx) begin
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                bus.mant_in   = 8'h11;
                repeat (stall_n) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_idx", 32'(bus.out_idx), 32'(k));
                    chk("stall_prob", 32'(bus.out_prob), 32'(e));
                end
                bus.out_ready = 1'b1;
                bus.in_valid  = 1'b0;
            end
            @(negedge clk);
        end
        chk("end_valid", 32'(bus.out_valid), 32'd0);
        chk("argmax_pulse", 32'(argmax_valid), 32'd1);
        chk("argmax", 32'(argmax), 32'(exp_am));
        chk("in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        @(negedge clk);
        chk("argmax_pulse_end", 32'(argmax_valid), 32'd0);
        chk("argmax_hold", 32'(argmax), 32'(exp_am));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mant_in   = '0;
        bus.exp_in    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_prob", 32'(bus.out_prob), 32'd0);
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_argmax", 32'(argmax), 32'd0);
        chk("rst_argmax_valid", 32'(argmax_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Frame A: 1/2, 1/4, underflow, then 2^-16 granules.
        send_frame(8'h80, {{7{8'hF0}}, 8'hEC, 8'hFE, 8'hFF});
        run_frame({{7{16'h0001}}, 16'h0000, 16'h4000, 16'h8000}, 4'd0, -1, 0, -1);

        // Frame B: saturation on classes 4 and 5; strictly larger exponent wins.
        send_frame(8'h80, {{4{8'hF0}}, 8'h01, 8'h00, {4{8'hF0}}});
        run_frame({{4{16'h0001}}, 16'hFFFF, 16'hFFFF, {4{16'h0001}}}, 4'd5, -1, 0, -1);

        // Frame C: all ties, with backpressure at idx 2 while in_valid is held high.
        send_frame(8'hC0, {10{8'hFD}});
        run_frame({10{16'h3000}}, 4'd0, 2, 3, -1);

        // Frame D: shift boundaries, most-negative exponent, and tie at the maximum.
        send_frame(8'hFF, {8'h7F, 8'h7F, 8'h80, 8'hEF, 8'hF0, 8'hF1, 8'hF9, 8'hF8, 8'h06, 8'h07});
        run_frame({16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0003,
                   16'h03FC, 16'h01FE, 16'hFFFF, 16'hFFFF}, 4'd8, -1, 0, -1);

        // Reset after the class-3 handshake of a frame.
        send_frame(8'h80, {{7{8'hF0}}, 8'hEC, 8'hFE, 8'hFF});
        run_frame({{7{16'h0001}}, 16'h0000, 16'h4000, 16'h8000}, 4'd0, -1, 0, 4);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_prob", 32'(bus.out_prob), 32'd0);
        chk("mid_rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("mid_rst_out_last", 32'(bus.out_last), 32'd0);
        chk("mid_rst_argmax", 32'(argmax), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_no_pulse", 32'(argmax_valid), 32'd0);
            chk("mid_rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready_rise", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_still_no_pulse", 32'(argmax_valid), 32'd0);

        // Recovery after reset.
        send_frame(8'hC0, {10{8'hFD}});
        run_frame({10{16'h3000}}, 4'd0, -1, 0, -1);

`ifdef PSM_SUM_CHECK_EN
        send_frame(8'h80, {{7{8'h80}}, 8'hFE, 8'hFE, 8'hFF});
        run_frame({{7{16'h0000}}, 16'h4000, 16'h4000, 16'h8000}, 4'd0, -1, 0, -1);
        chk("sum_ok_exact", 32'(sum_ok), 32'd1);
        send_frame(8'h80, {10{8'hFF}});
        run_frame({10{16'h8000}}, 4'd0, -1, 0, -1);
        chk("sum_ok_over", 32'(sum_ok), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
